// File: rtl/c3po_pkg.sv
// Shared types and constants for the c3po egress path.
package c3po_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } arb_state_e;

  localparam int unsigned VBC_W     = 8;
  localparam int unsigned BUS_BYTES = 32;

  // Index width for a port vector; never below 1 so single-port builds still elaborate.
  function automatic int unsigned port_idx_w(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/c3po_counter.sv
// Free-running wrapping counter with enable and increment amount.
module c3po_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic [Width-1:0] inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  // Synchronous clear; otherwise add inc_i when enabled (wraps naturally).
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + inc_i;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/c3po_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_i, with wrap-around.
module c3po_rr_pick
  import c3po_pkg::*;
#(
  parameter int unsigned Ports = 4,
  parameter int unsigned IdxW  = port_idx_w(Ports)
) (
  input  logic [Ports-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [Ports-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  // Walk the ports in priority order starting one past the previous winner.
  always_comb begin
    int j;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int off = 1; off <= int'(Ports); off++) begin
      j = (int'(last_i) + off) % int'(Ports);
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        idx_o       = IdxW'(j);
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c3po_egress_arb.sv
// Packet-atomic round-robin merge of per-port unpacker streams onto one egress bus.
module c3po_egress_arb
  import c3po_pkg::*;
#(
  parameter int unsigned PORTS_P    = 4,
  parameter int unsigned CNT_SIZE_P = 8,
  parameter int unsigned DATA_W_P   = 256
) (
  input  logic                                  clk_i,
  input  logic                                  reset_ni,
  input  logic [PORTS_P-1:0]                    in_val_i,
  input  logic [PORTS_P-1:0]                    in_sop_i,
  input  logic [PORTS_P-1:0]                    in_eop_i,
  input  logic [PORTS_P-1:0][VBC_W-1:0]         in_vbc_i,
  input  logic [PORTS_P-1:0][DATA_W_P-1:0]      in_data_i,
  output logic [PORTS_P-1:0]                    in_rdy_o,
  input  logic [PORTS_P-1:0]                    port_en_i,
  output logic                                  out_val_o,
  output logic                                  out_sop_o,
  output logic                                  out_eop_o,
  output logic [VBC_W-1:0]                      out_vbc_o,
  output logic [DATA_W_P-1:0]                   out_data_o,
  output logic [port_idx_w(PORTS_P)-1:0]        out_port_o,
  input  logic                                  out_rdy_i,
  output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]    pkt_cnt_o,
  output logic                                  busy_o
);

  localparam int unsigned PORT_IDX_W = port_idx_w(PORTS_P);

  arb_state_e            state_q, state_d;
  logic [PORT_IDX_W-1:0] grant_q, grant_d;
  logic [PORT_IDX_W-1:0] last_q, last_d;

  logic                  out_val_q, out_val_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [VBC_W-1:0]      out_vbc_q, out_vbc_d;
  logic [DATA_W_P-1:0]   out_data_q, out_data_d;
  logic [PORT_IDX_W-1:0] out_port_q, out_port_d;

  logic [PORTS_P-1:0]    req;
  logic [PORTS_P-1:0]    win_oh;
  logic [PORT_IDX_W-1:0] win_idx;
  logic                  win_any;
  logic                  grant_evt;
  logic                  accept;

  assign req = in_val_i & in_sop_i & port_en_i;

  c3po_rr_pick #(
    .Ports (PORTS_P),
    .IdxW  (PORT_IDX_W)
  ) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  assign grant_evt = (state_q == StIdle) && win_any;

  // Only the locked port is ever back-pressured open, and only when the output slot frees.
  always_comb begin
    in_rdy_o = '0;
    if (state_q == StLock) begin
      in_rdy_o[grant_q] = !out_val_q || out_rdy_i;
    end
  end

  assign accept = (state_q == StLock) && in_val_i[grant_q] && in_rdy_o[grant_q];

  // Next-state for the arbitration FSM and the egress register.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    out_val_d  = out_val_q;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_vbc_d  = out_vbc_q;
    out_data_d = out_data_q;
    out_port_d = out_port_q;

    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          state_d = StLock;
          grant_d = win_idx;
          last_d  = win_idx;
        end
      end
      StLock: begin
        if (accept && in_eop_i[grant_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Load on accept; drain when consumer takes the beat; otherwise hold everything stable.
    if (accept) begin
      out_val_d  = 1'b1;
      out_sop_d  = in_sop_i[grant_q];
      out_eop_d  = in_eop_i[grant_q];
      out_vbc_d  = in_vbc_i[grant_q];
      out_data_d = in_data_i[grant_q];
      out_port_d = grant_q;
    end else if (out_rdy_i) begin
      out_val_d  = 1'b0;
    end
  end

  // State and egress registers; reset points the search so port 0 wins first.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_q     <= PORT_IDX_W'(PORTS_P - 1);
      out_val_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_vbc_q  <= '0;
      out_data_q <= '0;
      out_port_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      out_val_q  <= out_val_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_vbc_q  <= out_vbc_d;
      out_data_q <= out_data_d;
      out_port_q <= out_port_d;
    end
  end

  for (genvar p = 0; p < int'(PORTS_P); p++) begin : g_cnt
    c3po_counter #(
      .Width (CNT_SIZE_P)
    ) u_cnt (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (grant_evt && win_oh[p]),
      .inc_i    (CNT_SIZE_P'(1)),
      .cnt_o    (pkt_cnt_o[p])
    );
  end

  assign out_val_o  = out_val_q;
  assign out_sop_o  = out_sop_q;
  assign out_eop_o  = out_eop_q;
  assign out_vbc_o  = out_vbc_q;
  assign out_data_o = out_data_q;
  assign out_port_o = out_port_q;
  assign busy_o     = (state_q == StLock);

endmodule

// File: tb/tb_c3po_egress_arb.sv
// Directed bench for c3po_egress_arb with a per-cycle behavioural reference model.
module tb_c3po_egress_arb;

  localparam int P  = 4;
  localparam int DW = 256;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [7:0]    vbc;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [1:0] port;
    beat_t      b;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [P-1:0]          in_val, in_sop, in_eop, in_rdy, port_en;
  logic [P-1:0][7:0]     in_vbc;
  logic [P-1:0][DW-1:0]  in_data;
  logic                  out_val, out_sop, out_eop, out_rdy, busy;
  logic [7:0]            out_vbc;
  logic [DW-1:0]         out_data;
  logic [1:0]            out_port;
  logic [P-1:0][7:0]     pkt_cnt;

  // Second instance with 2-bit counters, driven identically, to see counter wrap.
  logic [P-1:0]          in_rdy2;
  logic                  out_val2, out_sop2, out_eop2, busy2;
  logic [7:0]            out_vbc2;
  logic [DW-1:0]         out_data2;
  logic [1:0]            out_port2;
  logic [P-1:0][1:0]     pkt_cnt2;

  always #5 clk = ~clk;

  c3po_egress_arb #(.PORTS_P(P), .CNT_SIZE_P(8), .DATA_W_P(DW)) dut (
    .clk_i(clk), .reset_ni(rst_n), .in_val_i(in_val), .in_sop_i(in_sop), .in_eop_i(in_eop),
    .in_vbc_i(in_vbc), .in_data_i(in_data), .in_rdy_o(in_rdy), .port_en_i(port_en),
    .out_val_o(out_val), .out_sop_o(out_sop), .out_eop_o(out_eop), .out_vbc_o(out_vbc),
    .out_data_o(out_data), .out_port_o(out_port), .out_rdy_i(out_rdy), .pkt_cnt_o(pkt_cnt),
    .busy_o(busy)
  );

  c3po_egress_arb #(.PORTS_P(P), .CNT_SIZE_P(2), .DATA_W_P(DW)) dut2 (
    .clk_i(clk), .reset_ni(rst_n), .in_val_i(in_val), .in_sop_i(in_sop), .in_eop_i(in_eop),
    .in_vbc_i(in_vbc), .in_data_i(in_data), .in_rdy_o(in_rdy2), .port_en_i(port_en),
    .out_val_o(out_val2), .out_sop_o(out_sop2), .out_eop_o(out_eop2), .out_vbc_o(out_vbc2),
    .out_data_o(out_data2), .out_port_o(out_port2), .out_rdy_i(out_rdy), .pkt_cnt_o(pkt_cnt2),
    .busy_o(busy2)
  );

  int     n_vec = 0;
  int     n_err = 0;
  bit     started = 0;
  bit     clr = 0;
  bit     fired [P];
  beat_t  pq [P][$];
  ev_t    log_q [$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Source driver: pops beats the DUT took, presents queue heads just after each rising edge.
  initial begin
    in_val = '0; in_sop = '0; in_eop = '0; in_vbc = '0; in_data = '0;
    for (int p = 0; p < P; p++) fired[p] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < P; p++) begin
        if (clr) pq[p].delete();
        else if (fired[p] && pq[p].size() > 0) void'(pq[p].pop_front());
        if (pq[p].size() > 0) begin
          in_val[p] = 1'b1; in_sop[p] = pq[p][0].sop; in_eop[p] = pq[p][0].eop;
          in_vbc[p] = pq[p][0].vbc; in_data[p] = pq[p][0].data;
        end else begin
          in_val[p] = 1'b0; in_sop[p] = 1'b0; in_eop[p] = 1'b0;
          in_vbc[p] = '0; in_data[p] = '0;
        end
      end
      clr = 0;
    end
  end

  // Handshake sampler, after the test process has settled its per-cycle controls.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int p = 0; p < P; p++) fired[p] = rst_n && in_val[p] && in_rdy[p];
      if (rst_n && out_val && out_rdy) begin
        e.port = out_port;
        e.b = '{sop: out_sop, eop: out_eop, vbc: out_vbc, data: out_data};
        log_q.push_back(e);
      end
    end
  end

  // Reference model: who owns the bus, where the round-robin resumes, what sits in the egress slot.
  bit     m_locked = 0;
  int     m_grant = 0;
  int     m_last = P - 1;
  int     m_cnt [P];
  bit     m_val = 0;
  beat_t  m_out = '0;
  int     m_port = 0;

  initial begin
    for (int p = 0; p < P; p++) m_cnt[p] = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_locked = 0; m_grant = 0; m_last = P - 1; m_val = 0; m_out = '0; m_port = 0;
        for (int p = 0; p < P; p++) m_cnt[p] = 0;
      end else if (!m_locked) begin
        for (int k = 1; k <= P; k++) begin
          int c;
          c = (m_last + k) % P;
          if (!m_locked && in_val[c] && in_sop[c] && port_en[c]) begin
            m_locked = 1; m_grant = c; m_last = c; m_cnt[c] = (m_cnt[c] + 1) % 256;
          end
        end
        if (out_rdy) m_val = 0;
      end else begin
        if (in_val[m_grant] && (!m_val || out_rdy)) begin
          m_val = 1; m_port = m_grant;
          m_out = '{sop: in_sop[m_grant], eop: in_eop[m_grant], vbc: in_vbc[m_grant],
                    data: in_data[m_grant]};
          if (in_eop[m_grant]) m_locked = 0;
        end else if (out_rdy) begin
          m_val = 0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    logic [P-1:0] e_rdy;
    forever begin
      @(negedge clk);
      if (started) begin
        e_rdy = '0;
        if (m_locked && (!m_val || out_rdy)) e_rdy[m_grant] = 1'b1;
        chk("out_val", out_val, m_val);
        chk("out_sop", out_sop, m_out.sop);
        chk("out_eop", out_eop, m_out.eop);
        chk("out_vbc", out_vbc, m_out.vbc);
        chk("out_data", out_data, m_out.data);
        chk("out_port", out_port, m_port);
        chk("in_rdy", in_rdy, e_rdy);
        chk("busy", busy, m_locked);
        for (int p = 0; p < P; p++) begin
          chk($sformatf("pkt_cnt[%0d]", p), pkt_cnt[p], m_cnt[p]);
          chk($sformatf("pkt_cnt2[%0d]", p), pkt_cnt2[p], m_cnt[p] % 4);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; clr = 1; out_rdy = 1'b1; port_en = '1;
    step();
    rst_n = 1'b1;
    log_q.delete();
    chk("rst out_val", out_val, 0);
    chk("rst in_rdy", in_rdy, 0);
    chk("rst busy", busy, 0);
    chk("rst pkt_cnt", pkt_cnt, 0);
  endtask

  task automatic push_pkt(input int p, input int n, input int vlast, input int base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.sop = (k == 0); b.eop = (k == n - 1);
      b.vbc = (k == n - 1) ? 8'(vlast) : 8'd32;
      b.data = DW'(base + k);
      pq[p].push_back(b);
    end
  endtask

  task automatic wait_log(input string nm, input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin step(); c++; end
    chk({nm, " egress count reached"}, log_q.size() >= n, 1);
  endtask

  task automatic wait_second_beat(input string nm);
    int c = 0;
    while (!(out_val && !out_sop) && c < 30) begin step(); c++; end
    chk({nm, " second beat seen"}, out_val && !out_sop, 1);
  endtask

  initial begin
    int exp_wrap [5];
    int c;
    exp_wrap = '{1, 2, 3, 0, 1};
    out_rdy = 1'b1; port_en = '1;
    do_reset();
    started = 1;

    // Single 3-beat packet on port 2.
    push_pkt(2, 3, 5, 'h200);
    wait_log("t1", 3, 20);
    repeat (2) step();
    chk("t1 n", log_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1 port", log_q[k].port, 2);
      chk("t1 vbc", log_q[k].b.vbc, (k == 2) ? 5 : 32);
      chk("t1 data", log_q[k].b.data, 'h200 + k);
    end
    chk("t1 cnt2", pkt_cnt[2], 1);
    chk("t1 busy", busy, 0);

    // All ports with back-to-back single-beat packets: strict rotation.
    do_reset();
    for (int p = 0; p < P; p++) begin
      push_pkt(p, 1, p + 1, 'h100 * p);
      push_pkt(p, 1, 200, 'h100 * p + 'h80);
    end
    wait_log("t2", 8, 60);
    for (int k = 0; k < 8; k++) chk("t2 order", log_q[k].port, k % P);
    chk("t2 vbc", log_q[6].b.vbc, 200);
    for (int p = 0; p < P; p++) chk("t2 cnt", pkt_cnt[p], 2);

    // Back-pressure during beat 2 of a 4-beat port-1 packet.
    do_reset();
    push_pkt(1, 4, 7, 'h10);
    wait_second_beat("t3");
    out_rdy = 1'b0;
    repeat (5) begin
      step();
      chk("t3 in_rdy1", in_rdy[1], 0);
      chk("t3 hold", out_data, 'h11);
    end
    out_rdy = 1'b1;
    wait_log("t3", 4, 20);
    repeat (3) step();
    chk("t3 n", log_q.size(), 4);
    for (int k = 0; k < 4; k++) chk("t3 data", log_q[k].b.data, 'h10 + k);

    // Non-sop beat in IDLE is not a request.
    do_reset();
    pq[2].push_back('{sop: 1'b0, eop: 1'b1, vbc: 8'd4, data: '0});
    repeat (5) step();
    chk("stall in_rdy", in_rdy, 0);
    chk("stall busy", busy, 0);
    chk("stall n", log_q.size(), 0);

    // Enable dropped after port-3 grant.
    do_reset();
    push_pkt(3, 3, 9, 'h300);
    push_pkt(3, 1, 1, 'h380);
    c = 0;
    while (!busy && c < 10) begin step(); c++; end
    port_en[3] = 1'b0;
    wait_log("t4", 3, 20);
    repeat (8) step();
    chk("t4 n", log_q.size(), 3);
    chk("t4 vbc", log_q[2].b.vbc, 9);
    chk("t4 cnt", pkt_cnt[3], 1);
    chk("t4 busy", busy, 0);
    port_en[3] = 1'b1;
    wait_log("t4b", 4, 20);
    chk("t4 cnt2", pkt_cnt[3], 2);

    // Reset mid-packet on port 0, then port 1 wins ahead of port 3.
    do_reset();
    push_pkt(0, 4, 32, 'h400);
    wait_second_beat("t5");
    rst_n = 1'b0; clr = 1;
    step();
    rst_n = 1'b1;
    log_q.delete();
    chk("t5 out_val", out_val, 0);
    chk("t5 in_rdy", in_rdy, 0);
    chk("t5 pkt_cnt", pkt_cnt, 0);
    push_pkt(1, 1, 3, 'h510);
    push_pkt(3, 1, 3, 'h530);
    wait_log("t5", 2, 20);
    chk("t5 first", log_q[0].port, 1);
    chk("t5 second", log_q[1].port, 3);

    // 2-bit counter wrap on port 0.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_pkt(0, 1, 1, 'h600 + k);
      wait_log("t6", k + 1, 20);
      chk("t6 wrap", pkt_cnt2[0], exp_wrap[k]);
    end

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
